vc_input_buffer: RTL and testbench

Parametrised per-port input stage for the mesh NoC router: VC_NUM independent virtual-channel FIFOs behind one upstream link, with per-VC packet-state tracking, on/off credit signalling and protocol error detection. One instance sits on each router input (local, north, south, west, east). It feeds head-of-line flits to route computation and switch allocation, and drives `on_off_o` / `vc_allocatable_o` back to the upstream router.

---
 rtl/vc_input_buffer_if.sv | 25 ++
 rtl/vc_input_buffer.sv | 139 +++++++++++++
 tb/tb_vc_input_buffer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vc_input_buffer_if.sv
// Upstream-link and per-VC head-of-line bundle for vc_input_buffer.
// The buffer side uses the slave modport; the upstream/router side uses master.
interface vc_input_buffer_if #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned VC_NUM     = 2
);
    logic [FLIT_WIDTH-1:0]        data_i;
    logic                         valid_flit_i;
    logic [VC_NUM-1:0]            on_off_o;
    logic [VC_NUM-1:0]            vc_allocatable_o;
    logic [VC_NUM-1:0]            read_i;
    logic [VC_NUM*FLIT_WIDTH-1:0] data_o;
    logic [VC_NUM-1:0]            valid_o;
    logic [VC_NUM-1:0]            error_o;

    modport master (
        output data_i, valid_flit_i, read_i,
        input  on_off_o, vc_allocatable_o, data_o, valid_o, error_o
    );

    modport slave (
        input  data_i, valid_flit_i, read_i,
        output on_off_o, vc_allocatable_o, data_o, valid_o, error_o
    );
endinterface

// File: rtl/vc_input_buffer.sv
// Per-port NoC router input stage: VC_NUM FIFOs with packet FSMs, on/off flow control and
// protocol error flags. Define NOC_ERR_STICKY_EN to make error_o latch until reset.
module vc_input_buffer #(
    parameter int unsigned FLIT_WIDTH  = 32,
    parameter int unsigned VC_NUM      = 2,
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned OFF_MARGIN  = 2
) (
    input logic              clk,
    input logic              rst,
    vc_input_buffer_if.slave link
);
    localparam int unsigned VC_W  = $clog2(VC_NUM);
    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);

    localparam logic [1:0] FlitHead     = 2'b00;
    localparam logic [1:0] FlitBody     = 2'b01;
    localparam logic [1:0] FlitTail     = 2'b10;
    localparam logic [1:0] FlitHeadTail = 2'b11;

    typedef enum logic [1:0] {StIdle, StRecv, StDrain} vc_state_e;

    vc_state_e             state_q  [VC_NUM];
    vc_state_e             state_d  [VC_NUM];
    logic [PTR_W-1:0]      wr_ptr_q [VC_NUM];
    logic [PTR_W-1:0]      wr_ptr_d [VC_NUM];
    logic [PTR_W-1:0]      rd_ptr_q [VC_NUM];
    logic [PTR_W-1:0]      rd_ptr_d [VC_NUM];
    logic [CNT_W-1:0]      cnt_q    [VC_NUM];
    logic [CNT_W-1:0]      cnt_d    [VC_NUM];
    logic [FLIT_WIDTH-1:0] mem      [VC_NUM][BUFFER_SIZE];

    logic [VC_NUM-1:0] sel, legal, accept, pop;
    logic [VC_NUM-1:0] on_off_q, on_off_d, err_q, err_d;

    logic [1:0]      flit_type;
    logic [VC_W-1:0] flit_vc;
    logic            vc_ok;

    assign flit_type = link.data_i[FLIT_WIDTH-1 -: 2];
    assign flit_vc   = link.data_i[FLIT_WIDTH-3 -: VC_W];
    assign vc_ok     = 32'(flit_vc) < VC_NUM;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == BUFFER_SIZE - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        sel      = '0;
        legal    = '0;
        accept   = '0;
        pop      = '0;
        on_off_d = '0;
        err_d    = '0;
        // Out-of-range VC ids have no FIFO of their own; report them on VC 0.
        err_d[0] = link.valid_flit_i & ~vc_ok;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v]  = state_q[v];
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];

            sel[v] = link.valid_flit_i && vc_ok && (32'(flit_vc) == 32'(v));
            case (state_q[v])
                StIdle:  legal[v] = (flit_type == FlitHead) || (flit_type == FlitHeadTail);
                StRecv:  legal[v] = (flit_type == FlitBody) || (flit_type == FlitTail);
                default: legal[v] = 1'b0;
            endcase
            // Fullness uses the pre-read count: a same-cycle pop never frees the slot.
            accept[v] = sel[v] && legal[v] && (32'(cnt_q[v]) != BUFFER_SIZE);
            pop[v]    = link.read_i[v] && (cnt_q[v] != '0);
            err_d[v]  = err_d[v] | (sel[v] & ~accept[v]) | (link.read_i[v] & ~pop[v]);

            cnt_d[v] = cnt_q[v] + CNT_W'(accept[v]) - CNT_W'(pop[v]);
            if (accept[v]) wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
            if (pop[v])    rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);

            // Legality is already enforced, so the flit type alone picks the next state.
            if (accept[v]) begin
                case (flit_type)
                    FlitHead:               state_d[v] = StRecv;
                    FlitTail, FlitHeadTail: state_d[v] = StDrain;
                    default:                state_d[v] = state_q[v];
                endcase
            end
            if (state_q[v] == StDrain && cnt_d[v] == '0) state_d[v] = StIdle;

            on_off_d[v] = (32'(cnt_d[v]) + OFF_MARGIN) <= BUFFER_SIZE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v]  <= StIdle;
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            on_off_q <= '1;
            err_q    <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v]  <= state_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
            on_off_q <= on_off_d;
`ifdef NOC_ERR_STICKY_EN
            err_q <= err_q | err_d;
`else
            err_q <= err_d;
`endif
        end
    end

    // Storage needs no reset: data_o is masked whenever a VC is empty.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (accept[v]) mem[v][wr_ptr_q[v]] <= link.data_i;
        end
    end

    always_comb begin
        link.valid_o          = '0;
        link.vc_allocatable_o = '0;
        link.data_o           = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            link.valid_o[v]          = cnt_q[v] != '0;
            link.vc_allocatable_o[v] = state_q[v] == StIdle;
            if (cnt_q[v] != '0) link.data_o[v*FLIT_WIDTH +: FLIT_WIDTH] = mem[v][rd_ptr_q[v]];
        end
    end

    assign link.on_off_o = on_off_q;
    assign link.error_o  = err_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed table-driven bench for vc_input_buffer (2 VCs, depth 8, margin 2).
// Error expectations follow the pulse or sticky build of NOC_ERR_STICKY_EN.
module tb_vc_input_buffer;
    localparam int unsigned FW = 32;
    localparam int unsigned VN = 2;
    localparam int unsigned BS = 8;
    localparam int unsigned OM = 2;
`ifdef NOC_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vc_input_buffer_if #(.FLIT_WIDTH(FW), .VC_NUM(VN)) bus ();

    vc_input_buffer #(
        .FLIT_WIDTH (FW),
        .VC_NUM     (VN),
        .BUFFER_SIZE(BS),
        .OFF_MARGIN (OM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .link(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [31:0] d;
        logic [1:0]  rd;
        logic [1:0]  ev;
        logic [1:0]  ea;
        logic [1:0]  eo;
        logic [1:0]  ee;
        logic [63:0] ed;
    } vec_t;

    vec_t       tbl[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] err_acc = 2'b00;

    function automatic logic [31:0] flit(input logic [1:0] t, input logic vc, input logic [28:0] p);
        return {t, vc, p};
    endfunction

    function automatic logic [63:0] d0(input logic [31:0] f);
        return {32'h0, f};
    endfunction

    function automatic logic [63:0] d1(input logic [31:0] f);
        return {f, 32'h0};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ev, input logic [1:0] ea,
                              input logic [1:0] eo, input logic [1:0] ee, input logic [63:0] ed);
        logic [1:0] eerr;
        err_acc = err_acc | ee;
        eerr    = STICKY ? err_acc : ee;
        cmp({tag, " valid"},  64'(bus.valid_o),          64'(ev));
        cmp({tag, " alloc"},  64'(bus.vc_allocatable_o), 64'(ea));
        cmp({tag, " on_off"}, 64'(bus.on_off_o),         64'(eo));
        cmp({tag, " error"},  64'(bus.error_o),          64'(eerr));
        cmp({tag, " data"},   bus.data_o,                ed);
    endtask

    task automatic add(input logic wv, input logic [31:0] d, input logic [1:0] rd,
                       input logic [1:0] ev, input logic [1:0] ea, input logic [1:0] eo,
                       input logic [1:0] ee, input logic [63:0] ed);
        vec_t v;
        v.wv = wv; v.d = d; v.rd = rd;
        v.ev = ev; v.ea = ea; v.eo = eo; v.ee = ee; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.valid_flit_i = tbl[i].wv;
            bus.data_i       = tbl[i].d;
            bus.read_i       = tbl[i].rd;
            @(posedge clk);
            #1;
            bus.valid_flit_i = 1'b0;
            bus.data_i       = '0;
            bus.read_i       = '0;
            check_outs($sformatf("%s[%0d]", tag, i), tbl[i].ev, tbl[i].ea, tbl[i].eo, tbl[i].ee,
                       tbl[i].ed);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        bus.valid_flit_i = 1'b0;
        bus.data_i       = '0;
        bus.read_i       = '0;
        rst              = 1'b1;
        err_acc          = 2'b00;
        @(negedge clk);
        check_outs("reset", 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f, g, h, t, e0[9];
        int c;

        // Four-flit packet on VC1, then drained in order.
        do_reset();
        h = flit(HD, 1'b1, 29'h11);
        f = flit(BD, 1'b1, 29'h12);
        g = flit(BD, 1'b1, 29'h13);
        t = flit(TL, 1'b1, 29'h14);
        add(1, h, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, d1(h));
        add(1, f, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, d1(h));
        add(1, g, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, d1(h));
        add(1, t, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, d1(h));
        add(0, 0, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, d1(f));
        add(0, 0, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, d1(g));
        add(0, 0, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, d1(t));
        add(0, 0, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        run_tbl("pkt");

        // Fill VC0: on_off drops at count 7, 9th flit overflows.
        do_reset();
        e0[0] = flit(HD, 1'b0, 29'h100);
        for (int k = 1; k < 9; k++) e0[k] = flit(BD, 1'b0, 29'(32'h100 + k));
        add(1, e0[0], 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(e0[0]));
        for (int k = 1; k < 8; k++)
            add(1, e0[k], 2'b00, 2'b01, 2'b10, {1'b1, k <= 5}, 2'b00, d0(e0[0]));
        add(1, e0[8], 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, d0(e0[0]));
        for (int j = 0; j < 8; j++) begin
            c = 7 - j;
            add(0, 0, 2'b01, {1'b0, c != 0}, 2'b10, {1'b1, j >= 1}, 2'b00,
                (c != 0) ? d0(e0[j+1]) : 64'h0);
        end
        t = flit(TL, 1'b0, 29'h1ff);
        add(1, t, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(t));
        add(0, 0, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        run_tbl("fill");

        // Interleaved VC0/VC1 packets with concurrent pops, then push+pop on one VC.
        do_reset();
        begin
            logic [31:0] a0, a1, b0, b1, t0, t1;
            a0 = flit(HD, 1'b0, 29'h20); a1 = flit(HD, 1'b1, 29'h30);
            b0 = flit(BD, 1'b0, 29'h21); b1 = flit(BD, 1'b1, 29'h31);
            t0 = flit(TL, 1'b0, 29'h22); t1 = flit(TL, 1'b1, 29'h32);
            add(1, a0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(a0));
            add(1, a1, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, d1(a1));
            add(1, b0, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, d0(b0));
            add(1, b1, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, d1(b1));
            add(1, t0, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, d0(t0));
            add(1, t1, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, d1(t1));
            add(0, 0,  2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
            h = flit(HD, 1'b0, 29'h40);
            t = flit(TL, 1'b0, 29'h41);
            add(1, h,  2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
            add(1, t,  2'b01, 2'b01, 2'b10, 2'b11, 2'b00, d0(t));
            add(0, 0,  2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        end
        run_tbl("ilv");

        // Protocol errors: BODY in IDLE, HEAD in RECV, empty read, write in DRAIN.
        do_reset();
        h = flit(HD, 1'b0, 29'h51);
        t = flit(TL, 1'b0, 29'h53);
        add(1, flit(BD, 1'b0, 29'h50), 2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 64'h0);
        add(0, 0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        add(1, h, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
        add(1, flit(HD, 1'b0, 29'h52), 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, d0(h));
        add(0, 0, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, d0(h));
        add(0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
        add(1, t, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
        add(1, flit(BD, 1'b0, 29'h54), 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, d0(h));
        add(0, 0, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, d0(t));
        add(0, 0, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        run_tbl("err");

        // Pointer wrap with single-flit packets on VC1.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            f = flit(HT, 1'b1, 29'(32'h200 + i));
            add(1, f, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, d1(f));
            add(0, 0, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        end
        run_tbl("wrap");

        // Asynchronous reset mid-packet with five flits held on VC0.
        do_reset();
        h = flit(HD, 1'b0, 29'h60);
        add(1, h, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
        for (int k = 1; k < 5; k++)
            add(1, flit(BD, 1'b0, 29'(32'h60 + k)), 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
        run_tbl("pre_rst");
        #2;
        rst     = 1'b1;
        err_acc = 2'b00;
        #1;
        check_outs("rst_async", 2'b00, 2'b11, 2'b11, 2'b00, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        h = flit(HD, 1'b0, 29'h77);
        add(1, h, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, d0(h));
        add(0, 0, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 64'h0);
        run_tbl("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
